// File: rtl/reaction_game_ctrl_pkg.sv
// Shared definitions for the reaction-time game sequencer: FSM state encoding,
// LFSR seed/step and the result code reported on a timeout.
package reaction_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_GO    = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARM   = 3'd1;
    localparam logic [2:0] GO    = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] FAULT = 3'd4;

    localparam logic [7:0] LFSR_SEED    = 8'h01;
    localparam logic [7:0] TIMEOUT_CODE = 8'hFF;

    // Fibonacci step, taps 8,6,5,4; the all-zero state is unreachable from a non-zero seed
    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

endpackage

// File: rtl/reaction_game_ctrl_lfsr8.sv
// Free-running 8-bit LFSR that supplies the pseudo-random part of the LED-off delay.
module game_lfsr8
    import reaction_game_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] q
);

    logic [7:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= LFSR_SEED;
        end else begin
            q_reg <= lfsr_step(q_reg);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game sequencer: random LED-off delay, reaction measurement in ticks,
// false-start/timeout flags. Define BEST_SCORE_EN to track the best (minimum) result.
module reaction_game_ctrl
    import reaction_game_ctrl_pkg::*;
#(
    parameter int DELAY_MIN       = 50,
    parameter int DELAY_SPAN_LOG2 = 6,
    parameter int TIMEOUT         = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       button,
    output logic       led_on,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       false_start,
    output logic       timeout,
    output logic [7:0] best,
    output logic [2:0] state
);

    localparam logic [7:0] DELAY_BASE   = 8'(DELAY_MIN);
    localparam logic [7:0] SPAN_MASK    = 8'((1 << DELAY_SPAN_LOG2) - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic [7:0] delay_cnt_reg, delay_cnt_next;
    logic [7:0] react_cnt_reg, react_cnt_next;
    logic [7:0] result_reg, result_next;
    logic       result_valid_reg, result_valid_next;
    logic       false_start_reg, false_start_next;
    logic       timeout_reg, timeout_next;
    logic       led_on_reg;
    logic       button_q_reg;
    logic       press;
    logic [7:0] lfsr_q;
    logic [7:0] delay_load;

    game_lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    assign press      = button & ~button_q_reg;
    // A zero span gives an all-zero mask, so the delay collapses to DELAY_MIN
    assign delay_load = DELAY_BASE + (lfsr_q & SPAN_MASK);

`ifdef BEST_SCORE_EN
    logic [7:0] best_reg, best_next;
`endif

    always_comb begin
        state_next        = state_reg;
        delay_cnt_next    = delay_cnt_reg;
        react_cnt_next    = react_cnt_reg;
        result_next       = result_reg;
        result_valid_next = 1'b0;
        false_start_next  = false_start_reg;
        timeout_next      = timeout_reg;
`ifdef BEST_SCORE_EN
        best_next         = best_reg;
`endif
        case (state_reg)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start) begin
                    state_next       = ST_ARM;
                    delay_cnt_next   = delay_load;
                    false_start_next = 1'b0;
                    timeout_next     = 1'b0;
                end
            end
            ST_ARM: begin
                // An early press wins over a delay expiring in the same cycle
                if (press) begin
                    state_next       = ST_FAULT;
                    false_start_next = 1'b1;
                end else if (tick) begin
                    if (delay_cnt_reg == 8'd1) begin
                        state_next     = ST_GO;
                        react_cnt_next = 8'd0;
                    end else begin
                        delay_cnt_next = delay_cnt_reg - 8'd1;
                    end
                end
            end
            ST_GO: begin
                if (press) begin
                    state_next        = ST_DONE;
                    result_next       = react_cnt_reg;
                    result_valid_next = 1'b1;
`ifdef BEST_SCORE_EN
                    if (react_cnt_reg < best_reg) begin
                        best_next = react_cnt_reg;
                    end
`endif
                end else if (tick) begin
                    if (react_cnt_reg == TIMEOUT_LAST) begin
                        state_next        = ST_FAULT;
                        timeout_next      = 1'b1;
                        result_next       = TIMEOUT_CODE;
                        result_valid_next = 1'b1;
                    end else begin
                        react_cnt_next = react_cnt_reg + 8'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            delay_cnt_reg    <= 8'd0;
            react_cnt_reg    <= 8'd0;
            result_reg       <= 8'd0;
            result_valid_reg <= 1'b0;
            false_start_reg  <= 1'b0;
            timeout_reg      <= 1'b0;
            led_on_reg       <= 1'b0;
            button_q_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            delay_cnt_reg    <= delay_cnt_next;
            react_cnt_reg    <= react_cnt_next;
            result_reg       <= result_next;
            result_valid_reg <= result_valid_next;
            false_start_reg  <= false_start_next;
            timeout_reg      <= timeout_next;
            led_on_reg       <= (state_next == ST_GO);
            button_q_reg     <= button;
        end
    end

`ifdef BEST_SCORE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_reg <= TIMEOUT_CODE;
        end else begin
            best_reg <= best_next;
        end
    end

    assign best = best_reg;
`else
    assign best = TIMEOUT_CODE;
`endif

    assign led_on       = led_on_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign false_start  = false_start_reg;
    assign timeout      = timeout_reg;
    assign state        = state_reg;

endmodule
